// File: rtl/adam_aes_pkg.sv
// adam_aes_pkg: shared AES constants, S-box table, xtime and FSM state type
package adam_aes_pkg;
  localparam logic [7:0] RCON_INIT = 8'h01;
  localparam int AES128_ROUNDS = 10;
  typedef enum logic {IDLE, EXPAND} state_t;
  localparam logic [7:0] SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };
  function automatic logic [7:0] xtime(input logic [7:0] r);
    return {r[6:0], 1'b0} ^ (r[7] ? 8'h1b : 8'h00);
  endfunction
endpackage

// File: rtl/adam_aes_sbox.sv
// adam_aes_sbox: combinational AES S-box byte substitution
module adam_aes_sbox
  import adam_aes_pkg::*;
(
  input  logic [7:0] a,
  output logic [7:0] y
);
  assign y = SBOX[a];
endmodule

// File: rtl/adam_aes_key_expander.sv
// adam_aes_key_expander: AES-128 key schedule, one round key per cycle into an 11-entry register array
module adam_aes_key_expander
  import adam_aes_pkg::*;
#(
  parameter int NUM_ROUNDS = AES128_ROUNDS
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         init,
  input  logic         keylen,
  input  logic [127:0] key,
  output logic         ready,
  output logic         keys_valid,
  output logic         key_error,
  output logic [127:0] round_keys [0:10]
);
  state_t state, next_state;
  logic [7:0] rcon;
  logic [3:0] round_ctr, prev_idx;
  logic [127:0] prev, next_key;
  logic [31:0] rot, sub, t, n0, n1, n2, n3;
  logic accept, reject, last;
  assign accept = state == IDLE && init && !keylen;
  assign reject = state == IDLE && init && keylen;
  assign last = state == EXPAND && round_ctr == NUM_ROUNDS[3:0];
  assign prev_idx = round_ctr == 4'd0 ? 4'd0 : round_ctr - 4'd1;
  assign prev = round_keys[prev_idx];
  assign rot = {prev[23:0], prev[31:24]};
  genvar g;
  for (g = 0; g < 4; g++) begin : g_sub
    adam_aes_sbox u_sbox (.a(rot[8*g +: 8]), .y(sub[8*g +: 8]));
  end
  assign t = sub ^ {rcon, 24'h0};
  assign n0 = prev[127:96] ^ t;
  assign n1 = prev[95:64] ^ n0;
  assign n2 = prev[63:32] ^ n1;
  assign n3 = prev[31:0] ^ n2;
  assign next_key = {n0, n1, n2, n3};
  always_comb begin
    next_state = state;
    if (accept) next_state = EXPAND;
    if (last) next_state = IDLE;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      ready <= 1'b1;
      keys_valid <= 1'b0;
      key_error <= 1'b0;
      rcon <= 8'h00;
      round_ctr <= 4'd0;
    end else begin
      state <= next_state;
      ready <= next_state == IDLE;
      key_error <= reject;
      keys_valid <= accept ? 1'b0 : last ? 1'b1 : keys_valid;
      rcon <= accept ? RCON_INIT : state == EXPAND ? xtime(rcon) : rcon;
      round_ctr <= accept ? 4'd1 : state == EXPAND ? round_ctr + 4'd1 : round_ctr;
    end
  end
  // entry 0 takes the cipher key on load; entry i takes the next key while round_ctr == i
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i <= 10; i++) round_keys[i] <= '0;
    end else begin
      if (accept) round_keys[0] <= key;
      for (int i = 1; i <= 10; i++)
        if (state == EXPAND && round_ctr == i[3:0]) round_keys[i] <= next_key;
    end
  end
endmodule

// File: tb/tb_adam_aes_key_expander.sv
// tb_adam_aes_key_expander: randomized and vector checks against a GF(2^8)-derived key schedule model
module tb_adam_aes_key_expander;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic init = 1'b0;
  logic keylen = 1'b0;
  logic [127:0] key = '0;
  logic ready, keys_valid, key_error;
  logic [127:0] round_keys [0:10];
  logic [127:0] exp_keys [0:10];
  logic [7:0] sb [0:255];
  int total = 0;
  int bad = 0;
  localparam logic [127:0] KEY_A1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  always #5 clk = ~clk;

  adam_aes_key_expander dut (
    .clk(clk), .reset_n(reset_n), .init(init), .keylen(keylen), .key(key),
    .ready(ready), .keys_valid(keys_valid), .key_error(key_error), .round_keys(round_keys)
  );

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 0;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int k);
    return (b << k) | (b >> (8 - k));
  endfunction

  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 0;
      for (int y = 1; y < 256; y++)
        if (gmul(x[7:0], y[7:0]) == 8'h01) inv = y[7:0];
      sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic model(input logic [127:0] k);
    logic [31:0] w [0:43];
    logic [31:0] tmp;
    logic [7:0] rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sb[tmp[31:24]], sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]]} ^ {rc, 24'h0};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int r = 0; r <= 10; r++) exp_keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  // starts and ends at a negedge; hold keeps init high with a scrambled key throughout EXPAND
  task automatic run_expand(input logic [127:0] k, input bit hold);
    model(k);
    init = 1'b1; keylen = 1'b0; key = k;
    @(negedge clk);
    init = hold; key = hold ? {$urandom, $urandom, $urandom, $urandom} : k;
    total++; if (round_keys[0] !== k) begin bad++; $display("FAIL rk0 got=%h exp=%h", round_keys[0], k); end
    total++; if (ready !== 1'b0 || keys_valid !== 1'b0) begin bad++; $display("FAIL load_flags ready=%b valid=%b exp=0/0", ready, keys_valid); end
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      init = hold && i < 10;
      if (hold) key = {$urandom, $urandom, $urandom, $urandom};
      total++; if (round_keys[i] !== exp_keys[i]) begin bad++; $display("FAIL rk%0d got=%h exp=%h", i, round_keys[i], exp_keys[i]); end
      total++; if (keys_valid !== (i == 10) || ready !== (i == 10)) begin bad++; $display("FAIL step%0d_flags valid=%b ready=%b exp=%b", i, keys_valid, ready, i == 10); end
    end
    for (int i = 0; i <= 10; i++) begin
      total++; if (round_keys[i] !== exp_keys[i]) begin bad++; $display("FAIL final_rk%0d got=%h exp=%h", i, round_keys[i], exp_keys[i]); end
    end
    init = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    total++; if (ready !== 1'b1 || keys_valid !== 1'b0 || key_error !== 1'b0) begin bad++; $display("FAIL %s_flags ready=%b valid=%b err=%b exp=1/0/0", tag, ready, keys_valid, key_error); end
    for (int i = 0; i <= 10; i++) begin
      total++; if (round_keys[i] !== '0) begin bad++; $display("FAIL %s_rk%0d got=%h exp=0", tag, i, round_keys[i]); end
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    reset_n = 1'b1;
    @(negedge clk);
    check_reset_vals("post_reset");
  endtask

  task automatic test_fips();
    run_expand(KEY_A1, 1'b0);
    total++; if (round_keys[1] !== 128'ha0fafe1788542cb123a339392a6c7605) begin bad++; $display("FAIL a1_rk1 got=%h", round_keys[1]); end
    total++; if (round_keys[10] !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin bad++; $display("FAIL a1_rk10 got=%h", round_keys[10]); end
  endtask

  task automatic test_zero_key();
    run_expand('0, 1'b0);
    total++; if (round_keys[1] !== 128'h62636363626363636263636362636363) begin bad++; $display("FAIL zero_rk1 got=%h", round_keys[1]); end
    total++; if (round_keys[10] !== 128'hb4ef5bcb3e92e21123e951cf6f8f188e) begin bad++; $display("FAIL zero_rk10 got=%h", round_keys[10]); end
  endtask

  task automatic test_keylen_error();
    init = 1'b1; keylen = 1'b1; key = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    init = 1'b0; keylen = 1'b0;
    total++; if (key_error !== 1'b1) begin bad++; $display("FAIL err_pulse got=%b exp=1", key_error); end
    total++; if (ready !== 1'b1 || keys_valid !== 1'b1) begin bad++; $display("FAIL err_flags ready=%b valid=%b exp=1/1", ready, keys_valid); end
    for (int i = 0; i <= 10; i++) begin
      total++; if (round_keys[i] !== exp_keys[i]) begin bad++; $display("FAIL err_rk%0d got=%h exp=%h", i, round_keys[i], exp_keys[i]); end
    end
    @(negedge clk);
    total++; if (key_error !== 1'b0 || ready !== 1'b1 || keys_valid !== 1'b1) begin bad++; $display("FAIL err_after err=%b ready=%b valid=%b exp=0/1/1", key_error, ready, keys_valid); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 4; n++) run_expand({$urandom, $urandom, $urandom, $urandom}, n[0]);
  endtask

  task automatic test_init_held();
    run_expand({$urandom, $urandom, $urandom, $urandom}, 1'b1);
    @(negedge clk);
    total++; if (ready !== 1'b1 || keys_valid !== 1'b1) begin bad++; $display("FAIL held_idle ready=%b valid=%b exp=1/1", ready, keys_valid); end
  endtask

  task automatic test_reset_mid();
    init = 1'b1; key = KEY_A1;
    @(negedge clk);
    init = 1'b0;
    repeat (5) @(negedge clk);
    #2 reset_n = 1'b0;
    #1 check_reset_vals("mid_reset");
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    run_expand(KEY_A1, 1'b0);
  endtask

  task automatic test_back_to_back();
    run_expand(KEY_A1, 1'b0);
    run_expand('0, 1'b0);
  endtask

  initial begin
    build_sbox();
    test_reset();
    test_fips();
    test_keylen_error();
    test_zero_key();
    test_random();
    test_init_held();
    test_reset_mid();
    test_back_to_back();
    test_keylen_error();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end
endmodule

// File: doc/adam_aes_key_expander.md
# adam_aes_key_expander

AES-128 key schedule generator, upstream of the fully pipelined encipher. It accepts a 128-bit cipher key and produces the 11 round keys `round_keys[0:10]` that the encipher consumes, computing one round key per cycle. It holds the full schedule stable and flags it valid until the next accepted key load.

## Interface
Parameters:
- `NUM_ROUNDS`, 10: number of expansion rounds; fixed for AES-128, other values unsupported.

Ports:
- `clk`  in  1  clock; all state on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `init`  in  1  load `key` and start expansion; sampled only when `ready`=1.
- `keylen`  in  1  0 = AES-128 (supported); 1 = AES-256 (rejected).
- `key`  in  128  cipher key; bit 127 is the first key byte's MSB.
- `ready`  out  1  idle and able to accept `init`.
- `keys_valid`  out  1  `round_keys` complete and stable.
- `key_error`  out  1  one-cycle pulse when `init` is rejected.
- `round_keys`  out  128 x [0:10]  registered round keys; element i is round key i.

## Operation
- FSM has two states, IDLE and EXPAND.
- **IDLE, `init`=1, `keylen`=0:**
  - `round_keys[0]` <= `key`; `rcon` <= 8'h01; `round_ctr` <= 1.
  - `keys_valid` <= 0; `ready` <= 0; go to EXPAND.
- **IDLE, `init`=1, `keylen`=1:**
  - `key_error` <= 1 for one cycle; all other state is unchanged, including `keys_valid` and `round_keys`.
- **EXPAND, each cycle, for i = `round_ctr`:**
  - Let `prev` = `round_keys[i-1]`, split into words w0..w3 (w0 = bits 127:96).
  - t = SubWord(RotWord(w3)) ^ {`rcon`, 24'h0}. RotWord moves the top byte to the bottom.
  - n0 = w0^t; n1 = w1^n0; n2 = w2^n1; n3 = w3^n2; `round_keys[i]` <= {n0,n1,n2,n3}.
  - `rcon` <= xtime(`rcon`), where xtime = (r<<1) ^ (r[7] ? 8'h1B : 0), kept to 8 bits. The sequence is 01,02,04,08,10,20,40,80,1B,36.
  - `round_ctr` <= `round_ctr`+1. `round_ctr` is 4 bits wide.
  - When `round_ctr`==10: write `round_keys[10]`, go to IDLE, `ready` <= 1, `keys_valid` <= 1.
- `init` during EXPAND is ignored; there is no queuing and no error pulse.
- Changes on `key` after the `init` edge have no effect.
- `round_keys[j]` for j ≥ i keep their old values until overwritten; consumers gate on `keys_valid`.
- Upstream must not assert the encipher's `start` while `keys_valid`=0.

## Timing
- **Reset values:**
  - `ready`=1, `keys_valid`=0, `key_error`=0.
  - all `round_keys`=0, state IDLE, `rcon`=0, `round_ctr`=0.
- **Latency:**
  - `init` accepted at edge E0.
  - `round_keys[0]` is visible after E0.
  - `round_keys[i]` is visible after edge E0+i.
  - `keys_valid`=`ready`=1 after E0+10, so `ready` is low for exactly 10 cycles.
- **Back-to-back:** a new `init` is accepted in the first cycle `ready`=1. `keys_valid` drops after that edge.
- **Reset mid-EXPAND:** outputs return to reset values immediately (asynchronous). The partial schedule is discarded.
- `init` and a rejected `keylen` in the same cycle produce only the error pulse; the outputs do not change.
- All outputs are registered; there is no combinational path from input to output.

## Structure
- **Shared package `adam_aes_pkg`:**
  - 256-entry S-box constant table.
  - `xtime` function.
  - `RCON_INIT` = 8'h01.
  - `AES128_ROUNDS` = 10.
  - FSM state typedef, shared with the encipher's style.
- **Sub-module `adam_aes_sbox`:** combinational 8-to-8 lookup, instantiated 4 times for SubWord. The encipher's round module reuses the same sub-module.
- The expansion datapath is a single combinational next-key function feeding an 11-entry register array with a per-index write enable decoded from `round_ctr`.

## Test plan
- **FIPS-197 A.1 vector:** `key`=2b7e151628aed2a6abf7158809cf4f3c, `init` for 1 cycle.
  - `round_keys[1]`=a0fafe1788542cb123a339392a6c7605.
  - `round_keys[10]`=d014f9a8c9ee2589e13f0cc8b6630ca6.
  - `keys_valid` rises exactly 10 cycles after the `init` edge.
- **All-zero key:**
  - `round_keys[1]`=62636363626363636263636362636363.
  - `round_keys[10]`=b4ef5bcb3e92e21123e951cf6f8f188e.
  - `rcon` passes through 1B then 36.
- **`keylen`=1 with `init`:**
  - `key_error` is high for exactly one cycle.
  - `ready` stays 1.
  - `keys_valid` and `round_keys` keep the previous schedule.
- **`init` held during EXPAND with a different `key`:** the final schedule matches the first key only, and completion still takes 10 cycles.
- **`reset_n` low at cycle 5 of EXPAND:**
  - Outputs are at reset values immediately.
  - After release, a fresh A.1 expansion completes correctly.
- **Back-to-back:** A.1 key, then a zero key on the first `ready` cycle.
  - `keys_valid` drops for 10 cycles.
  - The second schedule is correct.
